serial_subtractor_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It computes an N-bit difference by time-sharing one full_subtractor cell over WIDTH clock cycles, LSB first.
- Operands are accepted with a start/ready handshake.
- The controller registers the borrow chain between cycles.
- It presents the result with a one-cycle done pulse.
- It sits between a register-file/operand source and any consumer that tolerates multi-cycle latency in exchange for minimal area.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the legal WIDTH range.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Borrow when b exceeds a, or when a==b and a borrow arrives from below.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller. One full_subtractor cell is
// time-shared over WIDTH cycles, LSB first, with the borrow registered
// between cycles.
// Optional: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_subtractor_ctrl: WIDTH out of range");
        end
    endgenerate

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res, res_nxt;
    logic [CNT_W-1:0] cnt;
    logic             brw;
    logic             d_cell, bout_cell;
    logic             last;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are lost once the shift registers start moving,
    // so they are kept aside at accept for the overflow test.
    logic a_msb, b_msb;
`endif

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d_cell),
        .bout (bout_cell)
    );

    // The new difference bit enters at the MSB so that after WIDTH shifts
    // the LSB computed first has landed at bit 0.
    assign res_nxt = (res >> 1) | (WIDTH'(d_cell) << (WIDTH - 1));
    assign last    = (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status decode; DONE always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, serial shifting and result load. diff/bout
    // hold the previous result until the final shift of the next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        brw  <= bin;
                        cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= res_nxt;
                    brw  <= bout_cell;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        diff <= res_nxt;
                        bout <= bout_cell;
`ifdef SERIAL_SUB_OVF_EN
                        // d_cell is the MSB of the final difference.
                        ovf <= (a_msb != b_msb) && (d_cell != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl (WIDTH=8).
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;
    localparam int LAT = W + 1;   // negedges from accept to done
    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         rst, start, bin;
    logic [W-1:0] a, b;
    logic         ready, busy, done, bout;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Issue one operation and return at the negedge where done is seen.
    // lat = negedges from accept to done, or -1 on timeout.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi, output int lat);
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ready, busy, done, bout} !== 4'b1000 || diff !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: ready/busy/done/bout=%b diff=%h, want 1000 00",
                     {ready, busy, done, bout}, diff);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        do_op(8'h05, 8'h03, 1'b0, lat);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        end
        n_checks++;
        if (diff !== 8'h02 || bout !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: diff=%h bout=%b ready=%b, want 02 0 0",
                     diff, bout, ready);
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: ready=%b done=%b, want 1 0", ready, done);
        end
    endtask

    task automatic test_borrow();
        int lat;
        do_op(8'h00, 8'h01, 1'b0, lat);
        n_checks++;
        if (lat !== LAT || diff !== 8'hFF || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow_0m1: lat=%0d diff=%h bout=%b, want 9 ff 1", lat, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_0m1: got %b want 0", ovf);
        end
`endif
        do_op(8'h80, 8'h01, 1'b0, lat);
        n_checks++;
        if (lat !== LAT || diff !== 8'h7F || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_80m01: lat=%0d diff=%h bout=%b, want 9 7f 0", lat, diff, bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_80m01: got %b want 1", ovf);
        end
`endif
    endtask

    task automatic test_hold();
        int lat;
        do_op(8'hFF, 8'hFF, 1'b1, lat);
        n_checks++;
        if (lat !== LAT || diff !== 8'hFF || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL ff_ff_bin: lat=%0d diff=%h bout=%b, want 9 ff 1", lat, diff, bout);
        end
        @(negedge clk);
        a = 8'h10; b = 8'h0F; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || diff !== 8'hFF || bout !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_prev: busy=%b diff=%h bout=%b, want 1 ff 1", busy, diff, bout);
        end
        lat = 4;
        while (!done && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== LAT || diff !== 8'h00 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_10m0f_bin: lat=%0d diff=%h bout=%b, want 9 00 0", lat, diff, bout);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h33; b = 8'h11;   // start stays high; must not disturb op in flight
        lat = 1;
        while (!done && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== LAT || diff !== 8'h05 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: lat=%0d diff=%h bout=%b, want 9 05 0", lat, diff, bout);
        end
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_after_done: ready=%b busy=%b, want 1 0", ready, busy);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_accept: busy=%b want 1", busy);
        end
        lat = 1;
        while (!done && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== LAT || diff !== 8'h22 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d diff=%h bout=%b, want 9 22 0", lat, diff, bout);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int seen_done = 0;
        @(negedge clk);
        a = 8'h03; b = 8'h05; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);   // fourth SHIFT cycle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ready, busy, done, bout} !== 4'b1000 || diff !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: ready/busy/done/bout=%b diff=%h, want 1000 00",
                     {ready, busy, done, bout}, diff);
        end
        repeat (12) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_done: done seen %0d times, want 0", seen_done);
        end
        do_op(8'h0A, 8'h0A, 1'b0, lat);
        n_checks++;
        if (lat !== LAT || diff !== 8'h00 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset_op: lat=%0d diff=%h bout=%b, want 9 00 0", lat, diff, bout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
